int_request_ctrl: RTL and testbench

- Interrupt request controller sitting directly upstream of the PC/interrupt stage in the multi-cycle CPU.
- Synchronises external IRQ lines, detects rising edges and latches pending requests.
- Applies per-line and global masks, then presents one prioritised request (INT, cause, handler vector) to the PC stage.
- Tracks in-service state until the return-from-exception (RFE) arrives; no nesting.

---
 rtl/int_request_ctrl_pkg.sv | 33 +++
 rtl/int_request_ctrl_irq_sync_edge.sv | 34 +++
 rtl/int_request_ctrl.sv | 132 +++++++++++++
 tb/tb_int_request_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/int_request_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : int_request_ctrl_pkg
// Purpose  : Shared FSM encoding, parameter defaults and width helper
// Revision : 1.0
// ============================================================================
package int_request_ctrl_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] C_ST_IDLE    = 2'b00;
    localparam logic [STATE_W-1:0] C_ST_REQ     = 2'b01;
    localparam logic [STATE_W-1:0] C_ST_SERVICE = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = C_ST_IDLE,
        REQ     = C_ST_REQ,
        SERVICE = C_ST_SERVICE
    } state_e;

    localparam int          NUM_IRQ_DEF     = 8;
    localparam int          SYNC_STAGES_DEF = 2;
    localparam logic [31:0] VEC_BASE_DEF    = 32'h0000_0004;
    localparam logic [31:0] VEC_STRIDE_DEF  = 32'h0000_0004;

    function automatic int cause_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CAUSE_W = cause_width(NUM_IRQ_DEF);

endpackage
`default_nettype wire

// File: rtl/int_request_ctrl_irq_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : irq_sync_edge
// Purpose  : One IRQ line: multi-flop synchroniser plus rising-edge pulse
// Revision : 1.0
// ============================================================================
module irq_sync_edge
    import int_request_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    output logic rise
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], irq};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/int_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : int_request_ctrl
// Purpose  : Synchronise/latch IRQ lines and present one prioritised request
// Revision : 1.0
// ============================================================================
module int_request_ctrl
    import int_request_ctrl_pkg::*;
#(
    parameter int          NUM_IRQ     = NUM_IRQ_DEF,
    parameter int          SYNC_STAGES = SYNC_STAGES_DEF,
    parameter logic [31:0] VEC_BASE    = VEC_BASE_DEF,
    parameter logic [31:0] VEC_STRIDE  = VEC_STRIDE_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_IRQ-1:0]              irq_in,
    input  logic [NUM_IRQ-1:0]              int_mask,
    input  logic                            int_en,
    input  logic                            int_ack,
    input  logic                            rfe,
    output logic                            INT,
    output logic [cause_width(NUM_IRQ)-1:0] cause_id,
    output logic [31:0]                     vector_pc,
    output logic                            in_service,
    output logic [NUM_IRQ-1:0]              pending
);

    localparam int CW = cause_width(NUM_IRQ);

    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_req;
    logic [NUM_IRQ-1:0] w_clr;
    logic [CW-1:0]      w_enc;
    logic               w_found;

    state_e             r_state;
    state_e             w_state_nxt;
    logic               r_int;
    logic               w_int_nxt;
    logic [CW-1:0]      r_cause;
    logic [CW-1:0]      w_cause_nxt;
    logic               r_insvc;
    logic               w_insvc_nxt;
    logic [NUM_IRQ-1:0] r_pending;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .clk   (clk),
            .reset (reset),
            .irq   (irq_in[g]),
            .rise  (w_rise[g])
        );
    end

    assign w_req = r_pending & int_mask;

    // Lowest index wins
    always_comb begin
        w_enc   = '0;
        w_found = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (w_req[i] && !w_found) begin
                w_enc   = CW'(i);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_int_nxt   = r_int;
        w_cause_nxt = r_cause;
        w_insvc_nxt = r_insvc;
        w_clr       = '0;
        case (r_state)
            IDLE: begin
                if (int_en && (|w_req)) begin
                    w_state_nxt = REQ;
                    w_int_nxt   = 1'b1;
                    w_cause_nxt = w_enc;
                end
            end
            REQ: begin
                if (int_ack) begin
                    w_clr       = {{(NUM_IRQ-1){1'b0}}, 1'b1} << r_cause;
                    w_int_nxt   = 1'b0;
                    w_insvc_nxt = 1'b1;
                    w_state_nxt = SERVICE;
                end
            end
            SERVICE: begin
                if (rfe) begin
                    w_insvc_nxt = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_int_nxt   = 1'b0;
                w_insvc_nxt = 1'b0;
            end
        endcase
    end

    // A fresh edge on the acknowledged line survives the clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_int     <= 1'b0;
            r_cause   <= '0;
            r_insvc   <= 1'b0;
            r_pending <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_int     <= w_int_nxt;
            r_cause   <= w_cause_nxt;
            r_insvc   <= w_insvc_nxt;
            r_pending <= (r_pending & ~w_clr) | w_rise;
        end
    end

    assign INT        = r_int;
    assign cause_id   = r_cause;
    assign in_service = r_insvc;
    assign pending    = r_pending;
    assign vector_pc  = VEC_BASE + ({{(32-CW){1'b0}}, r_cause} * VEC_STRIDE);

endmodule
`default_nettype wire

// File: tb/tb_int_request_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_request_ctrl
// Purpose  : Table, directed and random checks of int_request_ctrl
// Revision : 1.0
// ============================================================================
module tb_int_request_ctrl;

    localparam int N = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] irq_in;
    logic [N-1:0] int_mask;
    logic         int_en;
    logic         int_ack;
    logic         rfe;
    logic         INT;
    logic [2:0]   cause_id;
    logic [31:0]  vector_pc;
    logic         in_service;
    logic [N-1:0] pending;

    always #5 clk = ~clk;

    int_request_ctrl #(
        .NUM_IRQ     (N),
        .SYNC_STAGES (S),
        .VEC_BASE    (32'h0000_0004),
        .VEC_STRIDE  (32'h0000_0004)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .int_mask   (int_mask),
        .int_en     (int_en),
        .int_ack    (int_ack),
        .rfe        (rfe),
        .INT        (INT),
        .cause_id   (cause_id),
        .vector_pc  (vector_pc),
        .in_service (in_service),
        .pending    (pending)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: sample history, pending set, and a three-phase request
    logic [N-1:0] hist [0:S];
    int           m_phase;   // 0 waiting, 1 requesting, 2 servicing
    logic         m_int;
    logic         m_svc;
    int           m_cause;
    logic [N-1:0] m_pend;

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++)
            if (v[i]) return i;
        return 0;
    endfunction

    function automatic void model_reset();
        for (int j = 0; j <= S; j++) hist[j] = '0;
        m_phase = 0;
        m_int   = 1'b0;
        m_svc   = 1'b0;
        m_cause = 0;
        m_pend  = '0;
    endfunction

    function automatic void model_clock();
        logic [N-1:0] rises;
        logic [N-1:0] clr;
        rises = hist[S-1] & ~hist[S];
        clr   = '0;
        if (m_phase == 0) begin
            if (int_en && ((m_pend & int_mask) != 0)) begin
                m_phase = 1;
                m_int   = 1'b1;
                m_cause = lowest(m_pend & int_mask);
            end
        end else if (m_phase == 1) begin
            if (int_ack) begin
                clr[m_cause] = 1'b1;
                m_int   = 1'b0;
                m_svc   = 1'b1;
                m_phase = 2;
            end
        end else begin
            if (rfe) begin
                m_svc   = 1'b0;
                m_phase = 0;
            end
        end
        m_pend = (m_pend & ~clr) | rises;
        for (int j = S; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = irq_in;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("INT",        32'(INT),        32'(m_int));
        check("cause_id",   32'(cause_id),   32'(m_cause));
        check("vector_pc",  vector_pc,       32'h4 + 32'(m_cause) * 32'h4);
        check("in_service", 32'(in_service), 32'(m_svc));
        check("pending",    32'(pending),    32'(m_pend));
    endtask

    task automatic step();
        @(posedge clk);
        if (!reset) model_reset();
        else        model_clock();
        @(negedge clk);
        check_model();
    endtask

    typedef struct {
        logic [N-1:0] irq;
        logic         ack;
        logic         rf;
        logic         xint;
        logic [2:0]   xcause;
        logic         xsvc;
        logic [N-1:0] xpend;
    } vec_t;

    vec_t tbl [18];

    initial begin
        tbl[0]  = '{8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00};
        tbl[1]  = '{8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00};
        tbl[2]  = '{8'h08, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'h08};
        tbl[3]  = '{8'h08, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 8'h08};
        tbl[4]  = '{8'h08, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 8'h08};
        tbl[5]  = '{8'h08, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, 8'h00};
        tbl[6]  = '{8'h08, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 8'h00};
        tbl[7]  = '{8'h08, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 8'h00};
        tbl[8]  = '{8'h08, 1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 8'h00};
        tbl[9]  = '{8'h22, 1'b0, 1'b1, 1'b0, 3'd3, 1'b0, 8'h00};
        tbl[10] = '{8'h22, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 8'h00};
        tbl[11] = '{8'h22, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 8'h22};
        tbl[12] = '{8'h22, 1'b0, 1'b0, 1'b1, 3'd1, 1'b0, 8'h22};
        tbl[13] = '{8'h22, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 8'h20};
        tbl[14] = '{8'h22, 1'b0, 1'b1, 1'b0, 3'd1, 1'b0, 8'h20};
        tbl[15] = '{8'h22, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0, 8'h20};
        tbl[16] = '{8'h22, 1'b1, 1'b1, 1'b0, 3'd5, 1'b1, 8'h00};
        tbl[17] = '{8'h22, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 8'h00};

        irq_in   = '0;
        int_mask = '0;
        int_en   = 1'b0;
        int_ack  = 1'b0;
        rfe      = 1'b0;
        reset    = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // Idle after reset
        repeat (20) step();

        int_mask = 8'hFF;
        int_en   = 1'b1;
        for (int r = 0; r < 18; r++) begin
            irq_in  = tbl[r].irq;
            int_ack = tbl[r].ack;
            rfe     = tbl[r].rf;
            step();
            check($sformatf("tbl%0d_INT", r),     32'(INT),        32'(tbl[r].xint));
            check($sformatf("tbl%0d_cause", r),   32'(cause_id),   32'(tbl[r].xcause));
            check($sformatf("tbl%0d_vector", r),  vector_pc,       32'h4 + 32'(tbl[r].xcause) * 32'h4);
            check($sformatf("tbl%0d_svc", r),     32'(in_service), 32'(tbl[r].xsvc));
            check($sformatf("tbl%0d_pending", r), 32'(pending),    32'(tbl[r].xpend));
        end
        int_ack = 1'b0;
        rfe     = 1'b0;

        // Masked line stays pending without a request until unmasked
        int_mask = 8'hFE;
        irq_in   = 8'h23;
        repeat (4) step();
        check("mask_INT", 32'(INT), 32'h0);
        check("mask_pending", 32'(pending), 32'h01);
        int_mask = 8'hFF;
        step();
        check("unmask_INT", 32'(INT), 32'h1);
        check("unmask_cause", 32'(cause_id), 32'h0);
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;

        // New edge during service accumulates; stray ack ignored
        irq_in = 8'h27;
        step();
        int_ack = 1'b1;
        step();
        int_ack = 1'b0;
        repeat (2) step();
        check("svc_pending", 32'(pending), 32'h04);
        check("svc_INT", 32'(INT), 32'h0);
        check("svc_in_service", 32'(in_service), 32'h1);
        rfe = 1'b1;
        step();
        rfe = 1'b0;
        check("rfe_INT", 32'(INT), 32'h0);
        step();
        check("post_rfe_INT", 32'(INT), 32'h1);
        check("post_rfe_cause", 32'(cause_id), 32'h2);
        check("post_rfe_vector", vector_pc, 32'h0000_000C);

        // Asynchronous reset while requesting
        #2;
        reset = 1'b0;
        #1;
        check("arst_INT", 32'(INT), 32'h0);
        check("arst_pending", 32'(pending), 32'h0);
        check("arst_in_service", 32'(in_service), 32'h0);
        model_reset();
        repeat (2) step();
        reset = 1'b1;
        repeat (2) step();
        check("rel_pending_early", 32'(pending), 32'h0);
        step();
        check("rel_pending", 32'(pending), 32'h27);
        step();
        check("rel_INT", 32'(INT), 32'h1);

        // Randomised traffic against the model
        for (int k = 0; k < 400; k++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) irq_in[b] = ~irq_in[b];
            int_mask = ($urandom_range(0, 3) == 0) ? N'($urandom) : 8'hFF;
            int_en   = ($urandom_range(0, 7) != 0);
            int_ack  = ($urandom_range(0, 2) == 0);
            rfe      = ($urandom_range(0, 2) == 0);
            reset    = ($urandom_range(0, 99) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
